central_register_bank: RTL and testbench
========================================

// Module: central_register_bank
// PURPOSE
//  Responder for the service-gate decoder: holds the AGC central registers A, L, Q, Z, B
//  and acts on the decoded clear (C*G), write (W*G_n) and read (R*G_n) gate signals.
//  Clears and writes take effect on SIM_CLK edges; reads drive the wire-OR read bus.
//  It sits between the service-gate decoder and the write/read bus paths of the arithmetic unit.
// PARAMETERS
//  WIDTH     16  register and bus width (bit 16 = overflow/sign-2, bit 15 = sign)
//  MON_IDX_W 3   width of monitor register select (used only with CRB_MON_EN)
// PORTS
//  SIM_CLK   in  1      system clock, all state updates on rising edge
//  SIM_RST   in  1      reset, asynchronous, active-low
//  WL        in  WIDTH  write bus, active-high data
//  CAG CQG CZG CBG in 1 clear gates for A, Q, Z, B, active-high
//  CLG1G     in  1      clear L[14:1], active-high
//  CLG2G     in  1      clear L[16:15], active-high
//  WAG_n WLG_n WQG_n WZG_n WBG_n in 1 write gates, active-low
//  RAG_n RLG_n RQG_n RZG_n in 1 read gates (full word), active-low
//  RBHG_n    in  1      read B bits 16:9, active-low
//  RBLG_n    in  1      read B bits 8:1, active-low
//  RL        out WIDTH  read bus, OR of all enabled sources, 0 when none enabled
//  A_OVF     out 1      A[16] XOR A[15], registered with A
//  MON_SEL   in  MON_IDX_W monitor select (0=A 1=L 2=Q 3=Z 4=B, else 0) [CRB_MON_EN only]
//  MON_DATA  out WIDTH  monitor data [CRB_MON_EN only]
// BEHAVIOUR
//  - Reset (SIM_RST=0, async): A=L=Q=Z=B=0, A_OVF=0, MON_DATA=0; RL=0 follows.
//  - Per register R at rising edge: R <= (clear ? 0 : R) | (write ? WL : 0).
//    Clear and write in the same cycle => R = WL (clear-then-OR, AGC semantics).
//    Write without clear => R = R | WL (OR-in, never overwrite).
//  - L clear split: CLG1G zeroes bits 14:1 only, CLG2G bits 16:15 only; both => full clear.
//  - No clear and no write => hold. Gates for different registers are independent.
//  - RL combinational: OR of (A if !RAG_n), (L if !RLG_n), (Q if !RQG_n), (Z if !RZG_n),
//    ({B[16:9],8'b0} if !RBHG_n), ({8'b0,B[8:1]} if !RBLG_n). Multiple reads legal (wire-OR).
//  - Read same cycle as write/clear of that register returns pre-edge value; new value visible
//    on RL the cycle after the edge (zero-cycle read, one-cycle write latency).
//  - A_OVF recomputed from next A each edge; 1 for A[16:15]=01 or 10.
//  - Reset asserted mid-operation overrides all gates immediately; gates sampled only after
//    SIM_RST deasserts, first update on next rising edge.
//  - X/undriven gate inputs are a bench error; no internal resolution.
// CONFIGURATION
//  CRB_MON_EN defined: MON_SEL/MON_DATA present; MON_DATA registered, = selected register
//    value as of previous edge (1-cycle latency); MON_SEL 5..7 => 0. Does not load RL.
//  CRB_MON_EN undefined: MON_SEL/MON_DATA ports and monitor flop absent; no other change.
// TESTING
//  1 Reset: write A=16'h1234, assert SIM_RST=0 between edges -> A,RL(RAG_n=0),A_OVF=0 at once.
//  2 OR-in: A=16'h00F0, WAG_n=0 WL=16'h0F00, no CAG -> A=16'h0FF0; with CAG=1 same cycle -> A=16'h0F00.
//  3 L split clear: L=16'hFFFF, CLG1G=1 only -> L=16'hC000; then CLG2G=1 only -> L=16'h0000.
//  4 Wire-OR read: A=16'h0001, Q=16'h8000, RAG_n=RQG_n=0 -> RL=16'h8001; all read gates 1 -> RL=0.
//  5 B halves: B=16'hABCD, RBHG_n=0 -> RL=16'hAB00; RBLG_n=0 -> 16'h00CD; both -> 16'hABCD.
//  6 Overflow + monitor: write A=16'h4000 -> A_OVF=1 next cycle; with CRB_MON_EN, MON_SEL=0 ->
//    MON_DATA=16'h4000 one cycle later, MON_SEL=6 -> 0.

Source files
------------

// File: rtl/central_register_bank_if.sv
// Bus interface between the service-gate decoder (master) and the central register
// bank (slave): write bus, clear/write/read gates, the wire-OR read bus and A overflow.
// When CRB_MON_EN is defined the monitor select/data pair is carried as well.
interface central_register_bank_if #(
  parameter int WIDTH     = 16,
  parameter int MON_IDX_W = 3
);
  logic [WIDTH-1:0] WL;
  logic             CAG, CQG, CZG, CBG;
  logic             CLG1G, CLG2G;
  logic             WAG_n, WLG_n, WQG_n, WZG_n, WBG_n;
  logic             RAG_n, RLG_n, RQG_n, RZG_n;
  logic             RBHG_n, RBLG_n;
  logic [WIDTH-1:0] RL;
  logic             A_OVF;
`ifdef CRB_MON_EN
  logic [MON_IDX_W-1:0] MON_SEL;
  logic [WIDTH-1:0]     MON_DATA;
`endif

  modport master (
    output WL, CAG, CQG, CZG, CBG, CLG1G, CLG2G,
    output WAG_n, WLG_n, WQG_n, WZG_n, WBG_n,
    output RAG_n, RLG_n, RQG_n, RZG_n, RBHG_n, RBLG_n,
    input  RL, A_OVF
`ifdef CRB_MON_EN
    , output MON_SEL, input MON_DATA
`endif
  );

  modport slave (
    input  WL, CAG, CQG, CZG, CBG, CLG1G, CLG2G,
    input  WAG_n, WLG_n, WQG_n, WZG_n, WBG_n,
    input  RAG_n, RLG_n, RQG_n, RZG_n, RBHG_n, RBLG_n,
    output RL, A_OVF
`ifdef CRB_MON_EN
    , input MON_SEL, output MON_DATA
`endif
  );
endinterface

// File: rtl/central_register_bank.sv
// Central register bank: holds A, L, Q, Z, B and responds to decoded clear, write
// and read gates. Clear-then-OR update on each rising SIM_CLK edge, combinational
// wire-OR read bus, registered A overflow flag.
// Optional feature macro CRB_MON_EN adds a registered monitor port (MON_SEL/MON_DATA).
module central_register_bank #(
  parameter int WIDTH     = 16,
  parameter int MON_IDX_W = 3
) (
  input  logic                    SIM_CLK,
  input  logic                    SIM_RST,
  central_register_bank_if.slave  bus
);

  // L is cleared in two pieces: the low part (bits 14:1) and the top two bits (16:15)
  localparam int L_SPLIT = WIDTH - 2;

  logic [WIDTH-1:0] a_q, l_q, q_q, z_q, b_q;
  logic [WIDTH-1:0] a_next, l_next, q_next, z_next, b_next;
  logic [WIDTH-1:0] l_keep;
  logic             a_ovf_q;

  // Next values: clear first, then OR in the write bus; write never overwrites
  always_comb begin
    l_keep = '1;
    if (bus.CLG1G) l_keep[L_SPLIT-1:0]     = '0;
    if (bus.CLG2G) l_keep[WIDTH-1:L_SPLIT] = '0;
    a_next = (bus.CAG ? '0 : a_q) | (bus.WAG_n ? '0 : bus.WL);
    l_next = (l_q & l_keep)       | (bus.WLG_n ? '0 : bus.WL);
    q_next = (bus.CQG ? '0 : q_q) | (bus.WQG_n ? '0 : bus.WL);
    z_next = (bus.CZG ? '0 : z_q) | (bus.WZG_n ? '0 : bus.WL);
    b_next = (bus.CBG ? '0 : b_q) | (bus.WBG_n ? '0 : bus.WL);
  end

  // Register state and the overflow flag derived from the incoming A value
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      a_q     <= '0;
      l_q     <= '0;
      q_q     <= '0;
      z_q     <= '0;
      b_q     <= '0;
      a_ovf_q <= 1'b0;
    end else begin
      a_q     <= a_next;
      l_q     <= l_next;
      q_q     <= q_next;
      z_q     <= z_next;
      b_q     <= b_next;
      a_ovf_q <= a_next[WIDTH-1] ^ a_next[WIDTH-2];
    end
  end

  // Wire-OR read bus; B can be read as upper and lower halves independently
  always_comb begin
    bus.RL = '0;
    if (!bus.RAG_n)  bus.RL = bus.RL | a_q;
    if (!bus.RLG_n)  bus.RL = bus.RL | l_q;
    if (!bus.RQG_n)  bus.RL = bus.RL | q_q;
    if (!bus.RZG_n)  bus.RL = bus.RL | z_q;
    if (!bus.RBHG_n) bus.RL = bus.RL | {b_q[WIDTH-1:WIDTH/2], {(WIDTH/2){1'b0}}};
    if (!bus.RBLG_n) bus.RL = bus.RL | {{(WIDTH/2){1'b0}}, b_q[WIDTH/2-1:0]};
  end

  assign bus.A_OVF = a_ovf_q;

`ifdef CRB_MON_EN
  logic [WIDTH-1:0] mon_q;

  // Monitor snapshot of the selected register, one edge behind; unused selects read 0
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      mon_q <= '0;
    end else begin
      case (bus.MON_SEL)
        MON_IDX_W'(0): mon_q <= a_q;
        MON_IDX_W'(1): mon_q <= l_q;
        MON_IDX_W'(2): mon_q <= q_q;
        MON_IDX_W'(3): mon_q <= z_q;
        MON_IDX_W'(4): mon_q <= b_q;
        default:       mon_q <= '0;
      endcase
    end
  end

  assign bus.MON_DATA = mon_q;
`endif

endmodule

// File: tb/tb_central_register_bank.sv
// Self-checking bench for central_register_bank: directed vector table, reset and
// monitor sequences, then randomized gates against an array-based register model.
module tb_central_register_bank;

  logic SIM_CLK;
  logic SIM_RST;

  central_register_bank_if #(.WIDTH(16), .MON_IDX_W(3)) bus ();

  central_register_bank #(.WIDTH(16), .MON_IDX_W(3)) dut (
    .SIM_CLK (SIM_CLK),
    .SIM_RST (SIM_RST),
    .bus     (bus.slave)
  );

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  // clr: 0 A, 1 L[14:1], 2 L[16:15], 3 Q, 4 Z, 5 B
  // wr : 0 A, 1 L, 2 Q, 3 Z, 4 B
  // rd : 0 A, 1 L, 2 Q, 3 Z, 4 B high, 5 B low
  typedef struct {
    logic [5:0]  clr;
    logic [4:0]  wr;
    logic [5:0]  rd;
    logic [15:0] wl;
    logic [15:0] exp_rl;
    logic        exp_ovf;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [15:0] model [5];
  vec_t tbl [19];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.CAG    = v.clr[0];
    bus.CLG1G  = v.clr[1];
    bus.CLG2G  = v.clr[2];
    bus.CQG    = v.clr[3];
    bus.CZG    = v.clr[4];
    bus.CBG    = v.clr[5];
    bus.WAG_n  = ~v.wr[0];
    bus.WLG_n  = ~v.wr[1];
    bus.WQG_n  = ~v.wr[2];
    bus.WZG_n  = ~v.wr[3];
    bus.WBG_n  = ~v.wr[4];
    bus.RAG_n  = ~v.rd[0];
    bus.RLG_n  = ~v.rd[1];
    bus.RQG_n  = ~v.rd[2];
    bus.RZG_n  = ~v.rd[3];
    bus.RBHG_n = ~v.rd[4];
    bus.RBLG_n = ~v.rd[5];
    bus.WL     = v.wl;
  endtask

  function automatic logic [15:0] nextReg(input int idx, input logic [5:0] clr,
                                          input logic [4:0] wr, input logic [15:0] wl);
    logic [15:0] cleared;
    cleared = 16'h0000;
    case (idx)
      0: cleared = clr[0] ? 16'hFFFF : 16'h0000;
      1: cleared = (clr[1] ? 16'h3FFF : 16'h0000) | (clr[2] ? 16'hC000 : 16'h0000);
      2: cleared = clr[3] ? 16'hFFFF : 16'h0000;
      3: cleared = clr[4] ? 16'hFFFF : 16'h0000;
      default: cleared = clr[5] ? 16'hFFFF : 16'h0000;
    endcase
    return (model[idx] & ~cleared) | (wr[idx] ? wl : 16'h0000);
  endfunction

  function automatic logic [15:0] modelRead(input logic [5:0] rd);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) if (rd[i]) r |= model[i];
    if (rd[4]) r |= model[4] & 16'hFF00;
    if (rd[5]) r |= model[4] & 16'h00FF;
    return r;
  endfunction

  // One bus cycle: starts just after a rising edge, ends just after the next one
  task automatic doCycle(input vec_t v, input string tag);
    logic [15:0] nxt [5];
    applyStimulus(v);
    #1;
    checkOutput({tag, ".rl"}, bus.RL, v.exp_rl);
    for (int i = 0; i < 5; i++) nxt[i] = nextReg(i, v.clr, v.wr, v.wl);
    @(posedge SIM_CLK);
    for (int i = 0; i < 5; i++) model[i] = nxt[i];
    #1;
    checkOutput({tag, ".ovf"}, {15'b0, bus.A_OVF}, {15'b0, v.exp_ovf});
  endtask

  initial begin
    vec_t v;
    logic [15:0] na;

    tbl[0]  = '{clr:6'h00, wr:5'h01, rd:6'h00, wl:16'h00F0, exp_rl:16'h0000, exp_ovf:1'b0};
    tbl[1]  = '{clr:6'h00, wr:5'h01, rd:6'h01, wl:16'h0F00, exp_rl:16'h00F0, exp_ovf:1'b0};
    tbl[2]  = '{clr:6'h01, wr:5'h01, rd:6'h01, wl:16'h0F00, exp_rl:16'h0FF0, exp_ovf:1'b0};
    tbl[3]  = '{clr:6'h00, wr:5'h02, rd:6'h01, wl:16'hFFFF, exp_rl:16'h0F00, exp_ovf:1'b0};
    tbl[4]  = '{clr:6'h02, wr:5'h00, rd:6'h02, wl:16'h0000, exp_rl:16'hFFFF, exp_ovf:1'b0};
    tbl[5]  = '{clr:6'h04, wr:5'h00, rd:6'h02, wl:16'h0000, exp_rl:16'hC000, exp_ovf:1'b0};
    tbl[6]  = '{clr:6'h01, wr:5'h01, rd:6'h02, wl:16'h0001, exp_rl:16'h0000, exp_ovf:1'b0};
    tbl[7]  = '{clr:6'h00, wr:5'h04, rd:6'h01, wl:16'h8000, exp_rl:16'h0001, exp_ovf:1'b0};
    tbl[8]  = '{clr:6'h00, wr:5'h00, rd:6'h05, wl:16'h0000, exp_rl:16'h8001, exp_ovf:1'b0};
    tbl[9]  = '{clr:6'h00, wr:5'h10, rd:6'h00, wl:16'hABCD, exp_rl:16'h0000, exp_ovf:1'b0};
    tbl[10] = '{clr:6'h00, wr:5'h00, rd:6'h10, wl:16'h0000, exp_rl:16'hAB00, exp_ovf:1'b0};
    tbl[11] = '{clr:6'h00, wr:5'h00, rd:6'h20, wl:16'h0000, exp_rl:16'h00CD, exp_ovf:1'b0};
    tbl[12] = '{clr:6'h00, wr:5'h00, rd:6'h30, wl:16'h0000, exp_rl:16'hABCD, exp_ovf:1'b0};
    tbl[13] = '{clr:6'h01, wr:5'h01, rd:6'h00, wl:16'h4000, exp_rl:16'h0000, exp_ovf:1'b1};
    tbl[14] = '{clr:6'h00, wr:5'h00, rd:6'h01, wl:16'h0000, exp_rl:16'h4000, exp_ovf:1'b1};
    tbl[15] = '{clr:6'h00, wr:5'h01, rd:6'h01, wl:16'h8000, exp_rl:16'h4000, exp_ovf:1'b0};
    tbl[16] = '{clr:6'h01, wr:5'h01, rd:6'h08, wl:16'h8000, exp_rl:16'h0000, exp_ovf:1'b1};
    tbl[17] = '{clr:6'h20, wr:5'h08, rd:6'h30, wl:16'h1234, exp_rl:16'hABCD, exp_ovf:1'b1};
    tbl[18] = '{clr:6'h00, wr:5'h00, rd:6'h28, wl:16'h0000, exp_rl:16'h1234, exp_ovf:1'b1};

    for (int i = 0; i < 5; i++) model[i] = 16'h0000;
    v = '{clr:6'h00, wr:5'h00, rd:6'h3F, wl:16'hFFFF, exp_rl:16'h0000, exp_ovf:1'b0};
    applyStimulus(v);
`ifdef CRB_MON_EN
    bus.MON_SEL = 3'd0;
`endif
    SIM_RST = 1'b0;
    #12;
    checkOutput("reset.rl", bus.RL, 16'h0000);
    checkOutput("reset.ovf", {15'b0, bus.A_OVF}, 16'h0000);
`ifdef CRB_MON_EN
    checkOutput("reset.mon", bus.MON_DATA, 16'h0000);
`endif
    @(posedge SIM_CLK);
    #1;
    v.rd = 6'h00;
    applyStimulus(v);
    SIM_RST = 1'b1;

    // Directed vectors
    for (int i = 0; i < 19; i++) doCycle(tbl[i], $sformatf("vec%0d", i));

    // A = 8000 here; OR in 1234 -> 9234 with overflow, then reset mid-cycle
    v = '{clr:6'h00, wr:5'h01, rd:6'h01, wl:16'h1234, exp_rl:16'h8000, exp_ovf:1'b1};
    doCycle(v, "pre_reset");
    v = '{clr:6'h00, wr:5'h01, rd:6'h3F, wl:16'hFFFF, exp_rl:16'h0000, exp_ovf:1'b0};
    applyStimulus(v);
    #2;
    SIM_RST = 1'b0;
    #1;
    checkOutput("midreset.rl", bus.RL, 16'h0000);
    checkOutput("midreset.ovf", {15'b0, bus.A_OVF}, 16'h0000);
    @(posedge SIM_CLK);
    #1;
    checkOutput("heldreset.rl", bus.RL, 16'h0000);
    v = '{clr:6'h00, wr:5'h00, rd:6'h3F, wl:16'h0000, exp_rl:16'h0000, exp_ovf:1'b0};
    applyStimulus(v);
    SIM_RST = 1'b1;
    for (int i = 0; i < 5; i++) model[i] = 16'h0000;
    doCycle(v, "postreset");

`ifdef CRB_MON_EN
    v = '{clr:6'h01, wr:5'h01, rd:6'h00, wl:16'h4000, exp_rl:16'h0000, exp_ovf:1'b1};
    bus.MON_SEL = 3'd0;
    doCycle(v, "mon_wr");
    v = '{clr:6'h00, wr:5'h00, rd:6'h00, wl:16'h0000, exp_rl:16'h0000, exp_ovf:1'b1};
    doCycle(v, "mon_wait");
    checkOutput("mon.a", bus.MON_DATA, 16'h4000);
    bus.MON_SEL = 3'd6;
    doCycle(v, "mon_sel6");
    checkOutput("mon.sel6", bus.MON_DATA, 16'h0000);
    bus.MON_SEL = 3'd0;
`endif

    // Randomized gates against the register model
    for (int n = 0; n < 300; n++) begin
      for (int b = 0; b < 6; b++) v.clr[b] = ($urandom_range(0, 9) < 2);
      for (int b = 0; b < 5; b++) v.wr[b]  = ($urandom_range(0, 9) < 3);
      for (int b = 0; b < 6; b++) v.rd[b]  = ($urandom_range(0, 9) < 3);
      v.wl = 16'($urandom);
      v.exp_rl = modelRead(v.rd);
      na = nextReg(0, v.clr, v.wr, v.wl);
      v.exp_ovf = na[15] ^ na[14];
      doCycle(v, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
